outport_arbiter: RTL and testbench

//  Per-output-port round-robin switch arbiter, directly upstream of the output-port mux.

---
 rtl/outport_arbiter_pkg.sv | 22 ++
 rtl/outport_arbiter_rr_pick.sv | 33 +++
 rtl/outport_arbiter.sv | 96 +++++++++
 tb/tb_outport_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/outport_arbiter_pkg.sv
// Shared definitions for the router output-port arbiter: FSM encodings,
// default router sizes and the clog2 helper used by other router blocks.
package outport_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  localparam int DEF_NO_INPORT = 6;
  localparam int DEF_PHIT_SIZE = 32;

  // Never returns less than 1 so single-entry counters still get a bit.
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/outport_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or after ptr,
// wrapping past the last port back to port 0.
module rr_pick #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  reqs,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap so N need not be a power of two.
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && reqs[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/outport_arbiter.sv
// Per-output-port round-robin switch arbiter feeding the output-port mux.
// Optional grant-hold timeout is enabled by defining ARB_TIMEOUT_EN.
module outport_arbiter
  import outport_arbiter_pkg::*;
#(
  parameter  int no_inport    = DEF_NO_INPORT,
  parameter  int drain_cycles = 2,
  parameter  int timeout      = 64,
  localparam int IW           = clog2(no_inport)
) (
  input  logic                 clk,
  input  logic                 rs,
  input  logic [no_inport-1:0] reqs,
  input  logic                 release_sig,
  output logic [no_inport-1:0] select,
  output logic                 en,
  output logic [IW-1:0]        grant_idx,
  output logic                 timed_out
);

  localparam int DW = clog2(drain_cycles);

  arb_state_t           state;
  logic [IW-1:0]        ptr;
  logic [DW-1:0]        drain_cnt;
  logic [no_inport-1:0] pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [IW-1:0]        next_ptr;
  logic                 force_rel;

  rr_pick #(.N(no_inport), .IW(IW)) u_pick (
    .reqs   (reqs),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign next_ptr = (grant_idx == IW'(no_inport - 1)) ? '0 : grant_idx + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = clog2(timeout);
  logic [HW-1:0] hold;

  assign force_rel = (state == ARB_GRANT) && (hold == HW'(timeout - 1));

  always_ff @(posedge clk) begin
    if (rs || state != ARB_GRANT) hold <= '0;
    else                          hold <= hold + 1'b1;
  end
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rs) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      drain_cnt <= '0;
      select    <= '0;
      en        <= 1'b0;
      grant_idx <= '0;
      timed_out <= 1'b0;
    end else begin
      timed_out <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            select    <= pick_onehot;
            grant_idx <= pick_idx;
            en        <= 1'b1;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A real release wins over a simultaneous timeout.
          if (release_sig || force_rel) begin
            select    <= '0;
            en        <= 1'b0;
            ptr       <= next_ptr;
            drain_cnt <= DW'(drain_cycles - 1);
            timed_out <= force_rel && !release_sig;
            state     <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (drain_cnt == '0) state <= ARB_IDLE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outport_arbiter.sv
// Scoreboard bench for outport_arbiter: a per-edge reference model pushes the
// expected outputs, a negedge monitor pops and compares them.
module tb_outport_arbiter;

  localparam int N   = 6;
  localparam int DR  = 2;
  localparam int TMO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rs;
  logic [N-1:0] reqs;
  logic         release_sig;
  logic [N-1:0] select;
  logic         en;
  logic [2:0]   grant_idx;
  logic         timed_out;

  always #5 clk = ~clk;

  outport_arbiter #(.no_inport(N), .drain_cycles(DR), .timeout(TMO)) dut (
    .clk         (clk),
    .rs          (rs),
    .reqs        (reqs),
    .release_sig (release_sig),
    .select      (select),
    .en          (en),
    .grant_idx   (grant_idx),
    .timed_out   (timed_out)
  );

  typedef struct packed {
    logic [N-1:0] sel;
    logic         en;
    logic [2:0]   idx;
    logic         to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference state: current winner (-1 = none), priority pointer, drain cycles left.
  int m_g = -1, m_ptr = 0, m_drain = 0, m_hold = 0, m_idx = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_step();
    logic to;
    exp_t e;
    to = 1'b0;
    if (rs) begin
      m_g = -1; m_ptr = 0; m_drain = 0; m_hold = 0; m_idx = 0;
    end else if (m_g >= 0) begin
      m_hold++;
      if (release_sig || (TO_EN && m_hold >= TMO)) begin
        to      = !release_sig;
        m_ptr   = (m_g + 1) % N;
        m_g     = -1;
        m_drain = DR;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end else begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (reqs[p]) begin
          m_g = p; m_idx = p; m_hold = 0;
          break;
        end
      end
    end
    e.sel = (m_g >= 0) ? (6'b000001 << m_g) : 6'b0;
    e.en  = (m_g >= 0);
    e.idx = 3'(m_idx);
    e.to  = to;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_select", 32'(select), 32'(mon_e.sel));
      check("sb_en", 32'(en), 32'(mon_e.en));
      if (mon_e.en) check("sb_grant_idx", 32'(grant_idx), 32'(mon_e.idx));
      check("sb_timed_out", 32'(timed_out), 32'(mon_e.to));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input string nm);
    int n;
    n = 0;
    while (!en && n < 60) begin
      cyc();
      n++;
    end
    check(nm, 32'(en), 32'd1);
  endtask

  task automatic rel_pulse();
    release_sig = 1'b1;
    cyc();
    release_sig = 1'b0;
  endtask

  initial begin
    int hi, pulses, r;
    rs = 1'b1; reqs = '0; release_sig = 1'b0;
    cyc(); cyc();
    rs = 1'b0;
    // Reset and idle with no requests.
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("t1_select", 32'(select), 32'd0);
      check("t1_en", 32'(en), 32'd0);
      check("t1_idx", 32'(grant_idx), 32'd0);
    end

    // Single requester, fixed latency and drain gap.
    r = TO_EN ? 7 : 15;
    reqs = 6'b000100;
    cyc();
    check("t2_select", 32'(select), 32'h04);
    check("t2_en", 32'(en), 32'd1);
    repeat (r - 2) cyc();
    check("t2_held", 32'(select), 32'h04);
    rel_pulse();
    check("t2_rel_en", 32'(en), 32'd0);
    cyc();
    check("t2_drain1", 32'(en), 32'd0);
    cyc();
    check("t2_drain2", 32'(en), 32'd0);
    cyc();
    check("t2_regrant", 32'(select), 32'h04);
    reqs = '0;
    rel_pulse();

    // Rotation with all ports requesting.
    rs = 1'b1; cyc(); rs = 1'b0;
    reqs = 6'b111111;
    for (int k = 0; k < 7; k++) begin
      wait_en("t3_wait");
      check("t3_idx", 32'(grant_idx), 32'(k % N));
      cyc(); cyc();
      rel_pulse();
    end
    reqs = '0;

    // Wrap from ptr=5 and skip non-requesters.
    rs = 1'b1; cyc(); rs = 1'b0;
    reqs = 6'b010000;
    wait_en("t4_wait4");
    check("t4_idx4", 32'(grant_idx), 32'd4);
    rel_pulse();
    reqs = 6'b001010;
    wait_en("t4_wait1");
    check("t4_idx1", 32'(grant_idx), 32'd1);
    rel_pulse();
    wait_en("t4_wait3");
    check("t4_idx3", 32'(grant_idx), 32'd3);
    rel_pulse();
    reqs = '0;

    // Ignored inputs: dropped request, release during drain, reset mid-grant.
    rs = 1'b1; cyc(); rs = 1'b0;
    reqs = 6'b000001;
    wait_en("t5_wait0");
    reqs = '0;
    repeat (3) cyc();
    check("t5_hold_en", 32'(en), 32'd1);
    check("t5_hold_sel", 32'(select), 32'h01);
    rel_pulse();
    cyc();
    reqs = 6'b100000;
    rel_pulse();
    wait_en("t5_wait5");
    check("t5_idx5", 32'(grant_idx), 32'd5);
    rs = 1'b1; cyc(); rs = 1'b0;
    check("t5_rst_en", 32'(en), 32'd0);
    check("t5_rst_sel", 32'(select), 32'd0);
    check("t5_rst_idx", 32'(grant_idx), 32'd0);
    reqs = '0;
    cyc();

    // Grant with no release: timeout or indefinite hold.
    reqs = 6'b000100;
    wait_en("t6_wait");
    reqs = '0;
    hi = 0; pulses = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (en) hi++;
      if (timed_out) pulses++;
    end
    check("t6_hold_cycles", 32'(hi), TO_EN ? 32'(TMO - 1) : 32'd100);
    check("t6_to_pulses", 32'(pulses), TO_EN ? 32'd1 : 32'd0);
    rel_pulse();
    repeat (4) cyc();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      reqs        = 6'($urandom);
      release_sig = ($urandom_range(0, 5) == 0);
      rs          = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rs = 1'b0; reqs = '0; release_sig = 1'b1;
    cyc();
    release_sig = 1'b0;
    repeat (5) cyc();
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
